// File: rtl/vga_timing_ctrl_if.sv
// Pixel address/data loop between the raster timing generator (master) and the picture mux (slave).
// Handshake: pos_valid qualifies pos_x/pos_y in the same cycle. There is no ready; the mux returns pos_data
// exactly PIX_LATENCY clocks later on every cycle, and the generator ignores it wherever pos_valid was low.
interface vga_timing_ctrl_if;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        pos_valid;
    logic [23:0] pos_data;

    modport master (output pos_x, pos_y, pos_valid, input pos_data);
    modport slave  (input pos_x, pos_y, pos_valid, output pos_data);
endinterface

// File: rtl/vga_timing_ctrl.sv
// Raster timing generator and pixel output stage: sweeps h/v counters, addresses the picture mux and
// drives sync, data-enable and RGB to the pins with colour and sync delayed by the same depth.
module vga_timing_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_POL    = 1'b0,
    parameter int PIX_LATENCY = 1
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              test_en,
    vga_timing_ctrl_if.master pix,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic [23:0]       vga_rgb,
    output logic              frame_end,
    output logic [7:0]        frame_cnt
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HA0     = H_SYNC + H_BACK;
    localparam int VA0     = V_SYNC + V_BACK;
    localparam int D       = PIX_LATENCY + 1;

    logic [9:0]   h_cnt;
    logic [9:0]   v_cnt;
    logic         h_last;
    logic         v_last;
    logic         hs_raw;
    logic         vs_raw;
    logic         de_raw;
    logic [D-1:0] hs_pipe;
    logic [D-1:0] vs_pipe;
    logic [D-1:0] de_pipe;
    logic [2:0]   bar_pipe [PIX_LATENCY];
    logic [23:0]  bar_colour;
    logic [23:0]  colour;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Decode is gated by rst so the mux sees no visible address while reset is held mid-line.
    always_comb begin
        h_last        = (int'(h_cnt) == H_TOTAL - 1);
        v_last        = (int'(v_cnt) == V_TOTAL - 1);
        hs_raw        = (int'(h_cnt) < H_SYNC);
        vs_raw        = (int'(v_cnt) < V_SYNC);
        de_raw        = !rst
                        && (int'(h_cnt) >= HA0) && (int'(h_cnt) < HA0 + H_ACTIVE)
                        && (int'(v_cnt) >= VA0) && (int'(v_cnt) < VA0 + V_ACTIVE);
        pix.pos_valid = de_raw;
        pix.pos_x     = de_raw ? h_cnt - 10'(HA0) : '0;
        pix.pos_y     = de_raw ? v_cnt - 10'(VA0) : '0;
        frame_end     = !rst && h_last && v_last;
    end

    always_comb begin
        bar_colour = 24'h000000;
        case (bar_pipe[PIX_LATENCY-1])
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
        colour = test_en ? bar_colour : pix.pos_data;
    end

    // Sync/DE travel D stages; RGB is registered one stage after pos_data lands, so both meet at the pins.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hs_pipe   <= '0;
            vs_pipe   <= '0;
            de_pipe   <= '0;
            vga_rgb   <= '0;
            frame_cnt <= '0;
            for (int i = 0; i < PIX_LATENCY; i++) bar_pipe[i] <= '0;
        end else begin
            hs_pipe     <= {hs_pipe[D-2:0], hs_raw};
            vs_pipe     <= {vs_pipe[D-2:0], vs_raw};
            de_pipe     <= {de_pipe[D-2:0], de_raw};
            bar_pipe[0] <= pix.pos_x[9:7];
            for (int i = 1; i < PIX_LATENCY; i++) bar_pipe[i] <= bar_pipe[i-1];
            vga_rgb     <= de_pipe[D-2] ? colour : 24'h0;
            if (frame_end) frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign vga_hs = hs_pipe[D-1] ^ ~SYNC_POL;
    assign vga_vs = vs_pipe[D-1] ^ ~SYNC_POL;
    assign vga_de = de_pipe[D-1];
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: a full-size 640x480 instance for line/sync/bar timing and a shrunken raster
// (16x6, active-high sync, two-deep mux) for frame counting, pixel ordering and mid-frame reset.
module tb_vga_timing_ctrl;
    logic        vga_clk;
    logic        rst_a, rst_b;
    logic        te_a, te_b;
    logic        a_hs, a_vs, a_de, a_fe;
    logic [23:0] a_rgb;
    logic [7:0]  a_fc;
    logic        b_hs, b_vs, b_de, b_fe;
    logic [23:0] b_rgb;
    logic [7:0]  b_fc;
    logic [23:0] b_mux_d1;

    int n_vec = 0;
    int n_bad = 0;
    logic [23:0] exp_q[$];
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    vga_timing_ctrl_if a_if ();
    vga_timing_ctrl_if b_if ();

    vga_timing_ctrl dut_a (
        .vga_clk(vga_clk), .rst(rst_a), .test_en(te_a), .pix(a_if),
        .vga_hs(a_hs), .vga_vs(a_vs), .vga_de(a_de), .vga_rgb(a_rgb),
        .frame_end(a_fe), .frame_cnt(a_fc)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_POL(1'b1), .PIX_LATENCY(2)
    ) dut_b (
        .vga_clk(vga_clk), .rst(rst_b), .test_en(te_b), .pix(b_if),
        .vga_hs(b_hs), .vga_vs(b_vs), .vga_de(b_de), .vga_rgb(b_rgb),
        .frame_end(b_fe), .frame_cnt(b_fc)
    );

    // clock / reset
    initial begin
        vga_clk = 1'b0;
        rst_a   = 1'b1;
        rst_b   = 1'b1;
        te_a    = 1'b1;
        te_b    = 1'b0;
    end
    always #5 vga_clk = ~vga_clk;

    // picture mux models: one and two register stages
    always_ff @(posedge vga_clk) a_if.pos_data <= {a_if.pos_x[7:0], a_if.pos_y[7:0], 8'h5A};
    always_ff @(posedge vga_clk) begin
        b_mux_d1       <= {b_if.pos_x[7:0], b_if.pos_y[7:0], 8'h5A};
        b_if.pos_data  <= b_mux_d1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic fill_q();
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 16; x++)
                exp_q.push_back({8'(x), 8'(y), 8'h5A});
    endtask

    // full-size instance: sync widths, DE window, test bars then mux data
    task automatic run_a();
        int hs_first = -1, hs_last = -1, hs_n = 0, de_first = -1, de_n = 0;
        int h, v, j, hj, vj, x, y;
        logic de_e, pv_e;
        logic [23:0] rgb_e;
        repeat (3) @(negedge vga_clk);
        check("a_rst_hs", 32'(a_hs), 32'd1);
        check("a_rst_vs", 32'(a_vs), 32'd1);
        check("a_rst_de", 32'(a_de), 32'd0);
        check("a_rst_rgb", 32'(a_rgb), 32'd0);
        check("a_rst_pv", 32'(a_if.pos_valid), 32'd0);
        rst_a = 1'b0;
        for (int ia = 1; ia < 29600; ia++) begin
            @(negedge vga_clk);
            if (ia <= 800 && !a_hs) begin
                if (hs_first < 0) hs_first = ia;
                hs_last = ia;
                hs_n++;
            end
            if (ia == 1601) check("a_vs_last_low", 32'(a_vs), 32'd0);
            if (ia == 1602) check("a_vs_release", 32'(a_vs), 32'd1);
            if (ia >= 28000) begin
                h    = ia % 800;
                v    = ia / 800;
                pv_e = (h >= 144 && h < 784 && v >= 35 && v < 515);
                check("a_pos_valid", 32'(a_if.pos_valid), 32'(pv_e));
                check("a_pos_x", 32'(a_if.pos_x), pv_e ? 32'(h - 144) : 32'd0);
                check("a_pos_y", 32'(a_if.pos_y), pv_e ? 32'(v - 35) : 32'd0);
                j    = ia - 2;
                hj   = j % 800;
                vj   = j / 800;
                de_e = (hj >= 144 && hj < 784 && vj >= 35 && vj < 515);
                x    = hj - 144;
                y    = vj - 35;
                if (!de_e)        rgb_e = 24'h0;
                else if (vj == 35) rgb_e = bars[x / 128];
                else              rgb_e = {8'(x), 8'(y), 8'h5A};
                check("a_de", 32'(a_de), 32'(de_e));
                check("a_rgb", 32'(a_rgb), 32'(rgb_e));
                check("a_frame_end", 32'(a_fe), 32'd0);
                if (ia < 28800 && a_de) begin
                    if (de_first < 0) de_first = ia;
                    de_n++;
                end
            end
            if (ia == 28900) te_a = 1'b0;
        end
        check("a_hs_first", 32'(hs_first), 32'd2);
        check("a_hs_last", 32'(hs_last), 32'd97);
        check("a_hs_width", 32'(hs_n), 32'd96);
        check("a_de_first", 32'(de_first), 32'd28146);
        check("a_de_per_line", 32'(de_n), 32'd640);
        check("a_frame_cnt", 32'(a_fc), 32'd0);
    endtask

    // shrunken raster scoreboard for cycle i after reset release (H_TOTAL 25, V_TOTAL 11, D 3)
    task automatic check_b_cycle(input int i, input bit full);
        int h, v, j;
        logic pv_e, hs_e, vs_e, de_e;
        logic [23:0] e;
        h = i % 25;
        v = (i / 25) % 11;
        check("b_frame_end", 32'(b_fe), 32'((i % 275) == 274));
        check("b_frame_cnt", 32'(b_fc), 32'((i / 275) % 256));
        if (full) begin
            pv_e = (h >= 7 && h < 23 && v >= 4 && v < 10);
            check("b_pos_valid", 32'(b_if.pos_valid), 32'(pv_e));
            check("b_pos_x", 32'(b_if.pos_x), pv_e ? 32'(h - 7) : 32'd0);
            check("b_pos_y", 32'(b_if.pos_y), pv_e ? 32'(v - 4) : 32'd0);
            j = i - 3;
            if (j < 0) begin
                hs_e = 1'b0; vs_e = 1'b0; de_e = 1'b0;
            end else begin
                hs_e = ((j % 25) < 4);
                vs_e = (((j / 25) % 11) < 2);
                de_e = ((j % 25) >= 7 && (j % 25) < 23 && ((j / 25) % 11) >= 4 && ((j / 25) % 11) < 10);
            end
            check("b_hs", 32'(b_hs), 32'(hs_e));
            check("b_vs", 32'(b_vs), 32'(vs_e));
            check("b_de", 32'(b_de), 32'(de_e));
            if (b_de) begin
                check("b_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("b_rgb", 32'(b_rgb), 32'(e));
                    if (exp_q.size() == 0) fill_q();
                end
            end else begin
                check("b_rgb_blank", 32'(b_rgb), 32'd0);
            end
        end
    endtask

    // shrunken raster: 256 frames, then reset at h=12 v=5 of frame 257 and restart
    task automatic run_b();
        int fe_n = 0;
        repeat (3) @(negedge vga_clk);
        check("b_rst_hs", 32'(b_hs), 32'd0);
        check("b_rst_vs", 32'(b_vs), 32'd0);
        check("b_rst_de", 32'(b_de), 32'd0);
        check("b_rst_fc", 32'(b_fc), 32'd0);
        check("b_rst_pv", 32'(b_if.pos_valid), 32'd0);
        rst_b = 1'b0;
        fill_q();
        for (int i = 1; i <= 70812; i++) begin
            @(negedge vga_clk);
            check_b_cycle(i, i < 550);
            if (i <= 70400 && b_fe) fe_n++;
        end
        check("b_frame_pulses", 32'(fe_n), 32'd256);
        check("b_mid_pv", 32'(b_if.pos_valid), 32'd1);
        check("b_mid_x", 32'(b_if.pos_x), 32'd5);
        check("b_mid_y", 32'(b_if.pos_y), 32'd1);
        rst_b = 1'b1;
        #1;
        check("b_rst_hold_pv", 32'(b_if.pos_valid), 32'd0);
        check("b_rst_hold_x", 32'(b_if.pos_x), 32'd0);
        check("b_rst_hold_y", 32'(b_if.pos_y), 32'd0);
        @(negedge vga_clk);
        check("b_rst2_hs", 32'(b_hs), 32'd0);
        check("b_rst2_vs", 32'(b_vs), 32'd0);
        check("b_rst2_de", 32'(b_de), 32'd0);
        check("b_rst2_rgb", 32'(b_rgb), 32'd0);
        check("b_rst2_fc", 32'(b_fc), 32'd0);
        check("b_rst2_fe", 32'(b_fe), 32'd0);
        repeat (2) @(negedge vga_clk);
        rst_b = 1'b0;
        exp_q.delete();
        fill_q();
        for (int i = 1; i <= 300; i++) begin
            @(negedge vga_clk);
            check_b_cycle(i, 1'b1);
        end
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #(10 * 90000);
        n_bad++;
        $display("FAIL watchdog: run did not complete within 90000 clocks");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog expired");
    end
endmodule
